// File: rtl/hybrid_core_sequencer.sv
// Front-end sequencer for the multi-mode transform core: accepts mode-tagged frame requests,
// drains the core before any mode switch, and re-times an output-valid strobe to the core latency.
module hybrid_core_sequencer #(
  parameter int LAT_DCT = 6,
  parameter int LAT_WHT = 4,
  parameter int LAT_DFT = 5,
  parameter int SETTLE  = 1,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             s_valid,
  input  logic [1:0]       s_mode,
  output logic             s_ready,
  output logic [1:0]       core_t_select,
  output logic             core_in_valid,
  output logic             out_valid,
  output logic [1:0]       out_mode,
  output logic             busy,
  output logic             err_mode,
  output logic [CNT_W-1:0] frames_done
);

  localparam int MAXL_A = (LAT_DCT > LAT_WHT) ? LAT_DCT : LAT_WHT;
  localparam int MAXL   = (MAXL_A > LAT_DFT) ? MAXL_A : LAT_DFT;
  localparam int SR_W   = MAXL - 1;
  localparam int IF_W   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SETTLE_ST} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cur_mode_q, cur_mode_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        pend_q, pend_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rdy_en_q;
  logic              civ_q;
  logic [SR_W-1:0]   sr_q;
  logic [IF_W-1:0]   infl_q, infl_d;
  logic              ov_q;
  logic [1:0]        om_q;
  logic              err_q;
  logic [CNT_W-1:0]  frames_q;

  logic              illegal, mismatch, drained, exit_w, rdy_c, clr_sr, accept;
  logic [1:0]        load_mode;

  assign illegal  = s_valid && (s_mode == 2'b11);
  assign mismatch = s_valid && !illegal && (s_mode != cur_mode_q);

  // The tap sits one stage before the latency point so out_valid/out_mode can be registered.
  always_comb begin
    case (cur_mode_q)
      2'b01:   exit_w = sr_q[LAT_WHT-2];
      2'b10:   exit_w = sr_q[LAT_DFT-2];
      default: exit_w = sr_q[LAT_DCT-2];
    endcase
  end

  assign infl_d  = infl_q + IF_W'(civ_q) - IF_W'(exit_w);
  assign drained = (infl_d == '0);

  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    sel_d      = sel_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    rdy_c      = 1'b0;
    clr_sr     = 1'b0;
    load_mode  = pend_q;
    case (state_q)
      IDLE: begin
        rdy_c = !mismatch;
        if (mismatch) begin
          load_mode = s_mode;
          clr_sr    = 1'b1;
          state_d   = SETTLE_ST;
        end else if (s_valid && !illegal && rdy_en_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        rdy_c = !mismatch;
        if (mismatch) begin
          pend_d  = s_mode;
          state_d = DRAIN;
        end else if (!s_valid && drained) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (s_valid && !illegal) begin
          pend_d = s_mode;
        end
        load_mode = pend_d;
        if (drained) begin
          clr_sr  = 1'b1;
          state_d = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_sr) begin
      cur_mode_d = load_mode;
      sel_d      = load_mode;
      cnt_d      = 3'(SETTLE - 1);
    end
    // Illegal-mode frames are always swallowed so the requester never stalls on them.
    if (illegal) begin
      rdy_c = 1'b1;
    end
  end

  assign s_ready = rdy_c && rdy_en_q;
  assign accept  = s_valid && s_ready && !illegal;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cur_mode_q <= 2'b00;
      sel_q      <= 2'b00;
      pend_q     <= 2'b00;
      cnt_q      <= 3'd0;
      rdy_en_q   <= 1'b0;
      civ_q      <= 1'b0;
      sr_q       <= '0;
      infl_q     <= '0;
      ov_q       <= 1'b0;
      om_q       <= 2'b00;
      err_q      <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      sel_q      <= sel_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      rdy_en_q   <= 1'b1;
      civ_q      <= accept;
      // Bits left past the old tap are flushed so a longer new latency cannot see them.
      sr_q       <= clr_sr ? '0 : {sr_q[SR_W-2:0], civ_q};
      infl_q     <= infl_d;
      ov_q       <= exit_w;
      om_q       <= cur_mode_q;
      err_q      <= s_valid && s_ready && illegal;
      frames_q   <= frames_q + CNT_W'(ov_q);
    end
  end

  assign core_t_select = sel_q;
  assign core_in_valid = civ_q;
  assign out_valid     = ov_q;
  assign out_mode      = om_q;
  assign err_mode      = err_q;
  assign frames_done   = frames_q;
  assign busy          = (state_q != IDLE) || (infl_q != '0) || civ_q || ov_q;

endmodule
